// File: rtl/axis_bram_pkg.sv
// Shared types and helpers for the AXI-Stream BRAM frame store-and-forward controller.
package axis_bram_pkg;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  localparam int MAX_BE_WIDTH      = 128;
  localparam int DEF_ADDR_WIDTH    = 12;
  localparam int DEF_PTR_WIDTH     = DEF_ADDR_WIDTH + 1;

  // Pointers carry one extra bit so a full-depth count is representable.
  function automatic int ptr_width(input int addr_width);
    return addr_width + 1;
  endfunction

  function automatic logic [MAX_BE_WIDTH-1:0] be_all_ones(input int be_width);
    logic [MAX_BE_WIDTH-1:0] mask;
    mask = '0;
    for (int i = 0; i < MAX_BE_WIDTH; i++) begin
      if (i < be_width) mask[i] = 1'b1;
    end
    return mask;
  endfunction

endpackage

// File: rtl/axis_bram_rdbuf.sv
// Two-entry output FIFO that absorbs the BRAM read latency on the drain side.
module axis_bram_rdbuf #(
  parameter int WIDTH = 65
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_idx;
  logic             rd_idx;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_idx <= 1'b0;
      rd_idx <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_idx] <= din;
        wr_idx      <= ~wr_idx;
      end
      if (pop) rd_idx <= ~rd_idx;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_idx];

endmodule

// File: rtl/axis_bram_frame_ctrl.sv
// Frame store-and-forward sequencer: fills BRAM from an AXI-Stream slave, then drains it in order.
//   state | meaning
//   FILL  | accept input beats, write them to BRAM from address 0
//   DRAIN | read the stored frame back out on the master stream
module axis_bram_frame_ctrl
  import axis_bram_pkg::*;
#(
  parameter int C_AXIS_BRAM_ADDR_WIDTH = 12,
  parameter int C_AXIS_BRAM_DATA_WIDTH = 64,
  parameter int C_AXIS_BRAM_DEPTH      = 2**C_AXIS_BRAM_ADDR_WIDTH
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic [C_AXIS_BRAM_DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic                                s_axis_tvalid,
  output logic                                s_axis_tready,
  input  logic                                s_axis_tlast,
  output logic [C_AXIS_BRAM_DATA_WIDTH-1:0]   m_axis_tdata,
  output logic                                m_axis_tvalid,
  input  logic                                m_axis_tready,
  output logic                                m_axis_tlast,
  output logic [C_AXIS_BRAM_ADDR_WIDTH-1:0]   bram_addr,
  output logic [C_AXIS_BRAM_DATA_WIDTH-1:0]   bram_din,
  input  logic [C_AXIS_BRAM_DATA_WIDTH-1:0]   bram_dout,
  output logic                                bram_en,
  output logic [C_AXIS_BRAM_DATA_WIDTH/8-1:0] bram_we,
  output logic [C_AXIS_BRAM_ADDR_WIDTH:0]     frame_len,
  output logic                                overflow
);

  localparam int AW    = C_AXIS_BRAM_ADDR_WIDTH;
  localparam int DW    = C_AXIS_BRAM_DATA_WIDTH;
  localparam int BE_W  = DW / 8;
  localparam int PTR_W = ptr_width(AW);
  localparam logic [BE_W-1:0]  BE_ONES  = BE_W'(be_all_ones(BE_W));
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(C_AXIS_BRAM_DEPTH - 1);

  state_t           state;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] frame_len_q;
  logic             overflow_q;
  logic             inflight;
  logic             inflight_last;

  logic             accept;
  logic             fill_done;
  logic             pop;
  logic             issue;
  logic             issue_last;
  logic [2:0]       credit;
  logic [1:0]       buf_count;
  logic [DW:0]      buf_head;

  assign s_axis_tready = reset_n && (state == FILL);
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign fill_done     = accept && (s_axis_tlast || (wr_ptr == LAST_PTR));

  assign m_axis_tvalid = reset_n && (buf_count != 2'd0);
  assign m_axis_tdata  = buf_head[DW-1:0];
  assign m_axis_tlast  = m_axis_tvalid && buf_head[DW];
  assign pop           = m_axis_tvalid && m_axis_tready;

  // Occupancy after this cycle's pop; a read may only be issued if its data will have a slot.
  assign credit     = 3'(buf_count) + 3'(inflight) - 3'(pop);
  assign issue      = reset_n && (state == DRAIN) && (rd_ptr < frame_len_q) && (credit < 3'd2);
  assign issue_last = (rd_ptr == frame_len_q - PTR_W'(1));

  assign bram_en   = issue;
  assign bram_we   = accept ? BE_ONES : '0;
  assign bram_addr = (state == DRAIN) ? rd_ptr[AW-1:0] : wr_ptr[AW-1:0];
  assign bram_din  = s_axis_tdata;
  assign frame_len = frame_len_q;
  assign overflow  = overflow_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= FILL;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      frame_len_q   <= '0;
      overflow_q    <= 1'b0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      inflight      <= issue;
      inflight_last <= issue_last;
      case (state)
        FILL: begin
          if (fill_done) begin
            frame_len_q <= wr_ptr + PTR_W'(1);
            wr_ptr      <= '0;
            state       <= DRAIN;
            if (!s_axis_tlast) overflow_q <= 1'b1;
          end else if (accept) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
          end
        end
        DRAIN: begin
          if (pop && m_axis_tlast) begin
            rd_ptr <= '0;
            state  <= FILL;
          end else if (issue) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  axis_bram_rdbuf #(
    .WIDTH (DW + 1)
  ) u_rdbuf (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (inflight),
    .pop     (pop),
    .din     ({inflight_last, bram_dout}),
    .head    (buf_head),
    .count   (buf_count)
  );

endmodule

// File: tb/tb_axis_bram_frame_ctrl.sv
// Bench for axis_bram_frame_ctrl with an 8-word BRAM model and a frame-splitting reference model.
module tb_axis_bram_frame_ctrl;

  localparam int AW    = 3;
  localparam int DW    = 64;
  localparam int DEPTH = 1 << AW;
  localparam int BEW   = DW / 8;
  localparam int FLW   = AW + 1;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic          s_axis_tlast;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tlast;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_din;
  logic [DW-1:0] bram_dout;
  logic          bram_en;
  logic [BEW-1:0] bram_we;
  logic [AW:0]   frame_len;
  logic          overflow;

  always #5 clk = ~clk;

  axis_bram_frame_ctrl #(
    .C_AXIS_BRAM_ADDR_WIDTH (AW),
    .C_AXIS_BRAM_DATA_WIDTH (DW),
    .C_AXIS_BRAM_DEPTH      (DEPTH)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .bram_addr     (bram_addr),
    .bram_din      (bram_din),
    .bram_dout     (bram_dout),
    .bram_en       (bram_en),
    .bram_we       (bram_we),
    .frame_len     (frame_len),
    .overflow      (overflow)
  );

  // Single-port BRAM with one-cycle read latency.
  logic [DW-1:0] mem [DEPTH];
  int we_bad = 0;
  int wr_log[$];
  always @(posedge clk) begin
    if (bram_we != '0) begin
      mem[bram_addr] <= bram_din;
      wr_log.push_back(int'(bram_addr));
      if (bram_we != {BEW{1'b1}}) we_bad <= we_bad + 1;
    end
    if (bram_en) bram_dout <= mem[bram_addr];
  end

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] in_data[$];
  logic          in_last[$];
  logic [DW-1:0] exp_data[$];
  logic          exp_last[$];
  logic [DW-1:0] obs_data[$];
  logic          obs_last[$];
  bit            exp_ovf = 1'b0;
  int            exp_flen = 0;

  int en_total, max_lead, stab_err, tready_viol;
  int first_en_cyc, first_vld_cyc, last_pop_cyc;

  task automatic clear_stim();
    in_data.delete(); in_last.delete();
    exp_data.delete(); exp_last.delete();
    obs_data.delete(); obs_last.delete();
    wr_log.delete();
  endtask

  task automatic add_frame(input int n, input bit rnd, input logic [DW-1:0] base);
    for (int i = 0; i < n; i++) begin
      in_data.push_back(rnd ? {$urandom(), $urandom()} : base * DW'(i + 1));
      in_last.push_back(i == n - 1);
    end
  endtask

  // Frames end on tlast or after DEPTH words; truncation without tlast sets sticky overflow.
  function automatic void build_expected();
    int cnt = 0;
    exp_data.delete(); exp_last.delete();
    foreach (in_data[i]) begin
      cnt++;
      exp_data.push_back(in_data[i]);
      if (in_last[i] || cnt == DEPTH) begin
        exp_last.push_back(1'b1);
        if (!in_last[i]) exp_ovf = 1'b1;
        exp_flen = cnt;
        cnt = 0;
      end else begin
        exp_last.push_back(1'b0);
      end
    end
  endfunction

  task automatic drive_in(input int gap);
    int idx = 0;
    int guard = 0;
    bit hs;
    while (idx < in_data.size() && guard < 2000) begin
      s_axis_tvalid = (gap == 0) || ($urandom_range(0, 99) >= gap);
      s_axis_tdata  = in_data[idx];
      s_axis_tlast  = in_last[idx];
      @(negedge clk);
      hs = s_axis_tvalid && s_axis_tready;
      @(posedge clk); #1;
      if (hs) idx++;
      guard++;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic collect(input int n, input int mode);
    int cyc = 0;
    int got = 0;
    bit stalled = 1'b0;
    logic [DW-1:0] held_d = '0;
    logic held_l = 1'b0;
    while (got < n && cyc < 2000) begin
      case (mode)
        0:       m_axis_tready = 1'b1;
        1:       m_axis_tready = (cyc % 3 == 0);
        default: m_axis_tready = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk);
      if (stalled && (!m_axis_tvalid || m_axis_tdata !== held_d || m_axis_tlast !== held_l))
        stab_err++;
      if ((bram_en || m_axis_tvalid) && s_axis_tready) tready_viol++;
      if (bram_en) begin
        if (en_total == 0) first_en_cyc = cyc;
        en_total++;
      end
      if (m_axis_tvalid && first_vld_cyc < 0) first_vld_cyc = cyc;
      stalled = m_axis_tvalid && !m_axis_tready;
      held_d  = m_axis_tdata;
      held_l  = m_axis_tlast;
      if (m_axis_tvalid && m_axis_tready) begin
        obs_data.push_back(m_axis_tdata);
        obs_last.push_back(m_axis_tlast);
        got++;
        last_pop_cyc = cyc;
      end
      if (en_total - got > max_lead) max_lead = en_total - got;
      @(posedge clk); #1;
      cyc++;
    end
    m_axis_tready = 1'b0;
  endtask

  task automatic run_stream(input int gap, input int mode, input int n_out);
    en_total = 0; max_lead = 0; stab_err = 0; tready_viol = 0;
    first_en_cyc = -1; first_vld_cyc = -1; last_pop_cyc = -1;
    fork
      drive_in(gap);
      collect(n_out, mode);
    join
  endtask

  task automatic test_reset();
    reset_n = 1'b0; s_axis_tvalid = 1'b1; s_axis_tdata = '0; s_axis_tlast = 1'b0;
    m_axis_tready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({s_axis_tready, m_axis_tvalid, bram_en} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_forced: tready/tvalid/en=%b want 000", {s_axis_tready, m_axis_tvalid, bram_en});
    end
    n_cmp++;
    if (bram_we !== '0) begin
      n_err++; $display("FAIL reset_we: got %h want 0", bram_we);
    end
    @(posedge clk); #1;
    reset_n = 1'b1; s_axis_tvalid = 1'b0; m_axis_tready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (frame_len !== '0 || overflow !== 1'b0) begin
      n_err++; $display("FAIL reset_regs: frame_len=%0d overflow=%b want 0/0", frame_len, overflow);
    end
    n_cmp++;
    if (s_axis_tready !== 1'b1 || m_axis_tvalid !== 1'b0) begin
      n_err++; $display("FAIL reset_fill: s_tready=%b m_tvalid=%b want 1/0", s_axis_tready, m_axis_tvalid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    clear_stim(); add_frame(4, 1'b0, 64'h11); build_expected();
    run_stream(0, 0, exp_data.size());
    n_cmp++;
    if (obs_data.size() != exp_data.size()) begin
      n_err++; $display("FAIL basic_count: got %0d want %0d", obs_data.size(), exp_data.size());
    end
    for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
      n_cmp++;
      if (obs_data[i] !== exp_data[i] || obs_last[i] !== exp_last[i]) begin
        n_err++;
        $display("FAIL basic_beat%0d: got %h/%b want %h/%b", i, obs_data[i], obs_last[i], exp_data[i], exp_last[i]);
      end
    end
    n_cmp++;
    if (wr_log.size() != 4 || wr_log[0] != 0 || wr_log[1] != 1 || wr_log[2] != 2 || wr_log[3] != 3 || we_bad != 0) begin
      n_err++; $display("FAIL basic_writes: %0d writes, we_bad=%0d want addrs 0..3", wr_log.size(), we_bad);
    end
    n_cmp++;
    if (first_vld_cyc - first_en_cyc != 2) begin
      n_err++; $display("FAIL basic_latency: got %0d want 2", first_vld_cyc - first_en_cyc);
    end
    n_cmp++;
    if (last_pop_cyc - first_vld_cyc != 3) begin
      n_err++; $display("FAIL basic_bubbles: span %0d want 3", last_pop_cyc - first_vld_cyc);
    end
    n_cmp++;
    if (frame_len !== FLW'(exp_flen)) begin
      n_err++; $display("FAIL basic_frame_len: got %0d want %0d", frame_len, exp_flen);
    end
  endtask

  task automatic test_backpressure();
    clear_stim(); add_frame(4, 1'b0, 64'h11); build_expected();
    run_stream(0, 1, exp_data.size());
    n_cmp++;
    if (obs_data.size() != exp_data.size()) begin
      n_err++; $display("FAIL bp_count: got %0d want %0d", obs_data.size(), exp_data.size());
    end
    for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
      n_cmp++;
      if (obs_data[i] !== exp_data[i] || obs_last[i] !== exp_last[i]) begin
        n_err++;
        $display("FAIL bp_beat%0d: got %h/%b want %h/%b", i, obs_data[i], obs_last[i], exp_data[i], exp_last[i]);
      end
    end
    n_cmp++;
    if (stab_err != 0 || max_lead > 2 || en_total != 4) begin
      n_err++; $display("FAIL bp_flow: stab_err=%0d lead=%0d reads=%0d want 0/<=2/4", stab_err, max_lead, en_total);
    end
  endtask

  task automatic test_single();
    clear_stim(); add_frame(1, 1'b1, '0); build_expected();
    run_stream(0, 0, exp_data.size());
    n_cmp++;
    if (obs_data.size() != 1 || obs_data[0] !== exp_data[0] || obs_last[0] !== 1'b1) begin
      n_err++; $display("FAIL single_beat: got %0d beats, first %h want %h with tlast", obs_data.size(), obs_data.size() ? obs_data[0] : '0, exp_data[0]);
    end
    n_cmp++;
    if (en_total != 1 || frame_len !== FLW'(1)) begin
      n_err++; $display("FAIL single_reads: reads=%0d frame_len=%0d want 1/1", en_total, frame_len);
    end
  endtask

  task automatic test_back_to_back();
    clear_stim(); add_frame(3, 1'b1, '0); add_frame(5, 1'b1, '0); build_expected();
    run_stream(0, 0, exp_data.size());
    n_cmp++;
    if (obs_data.size() != exp_data.size()) begin
      n_err++; $display("FAIL b2b_count: got %0d want %0d", obs_data.size(), exp_data.size());
    end
    for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
      n_cmp++;
      if (obs_data[i] !== exp_data[i] || obs_last[i] !== exp_last[i]) begin
        n_err++;
        $display("FAIL b2b_beat%0d: got %h/%b want %h/%b", i, obs_data[i], obs_last[i], exp_data[i], exp_last[i]);
      end
    end
    n_cmp++;
    if (tready_viol != 0 || frame_len !== FLW'(exp_flen)) begin
      n_err++; $display("FAIL b2b_drain: tready_viol=%0d frame_len=%0d want 0/%0d", tready_viol, frame_len, exp_flen);
    end
  endtask

  task automatic test_overflow();
    clear_stim(); add_frame(10, 1'b1, '0); build_expected();
    run_stream(0, 0, exp_data.size());
    n_cmp++;
    if (obs_data.size() != exp_data.size()) begin
      n_err++; $display("FAIL ovf_count: got %0d want %0d", obs_data.size(), exp_data.size());
    end
    for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
      n_cmp++;
      if (obs_data[i] !== exp_data[i] || obs_last[i] !== exp_last[i]) begin
        n_err++;
        $display("FAIL ovf_beat%0d: got %h/%b want %h/%b", i, obs_data[i], obs_last[i], exp_data[i], exp_last[i]);
      end
    end
    n_cmp++;
    if (overflow !== exp_ovf || frame_len !== FLW'(exp_flen)) begin
      n_err++; $display("FAIL ovf_flags: overflow=%b frame_len=%0d want %b/%0d", overflow, frame_len, exp_ovf, exp_flen);
    end
  endtask

  task automatic test_reset_mid();
    clear_stim(); add_frame(6, 1'b1, '0); build_expected();
    run_stream(0, 0, 2);
    n_cmp++;
    if (obs_data.size() != 2 || obs_data[0] !== exp_data[0] || obs_data[1] !== exp_data[1]) begin
      n_err++; $display("FAIL midrst_prefix: got %0d beats want first 2 of frame", obs_data.size());
    end
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    exp_ovf = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (m_axis_tvalid !== 1'b0 || overflow !== 1'b0 || frame_len !== '0 || s_axis_tready !== 1'b1) begin
      n_err++;
      $display("FAIL midrst_state: tvalid=%b ovf=%b frame_len=%0d s_tready=%b want 0/0/0/1", m_axis_tvalid, overflow, frame_len, s_axis_tready);
    end
    @(posedge clk); #1;
    clear_stim(); add_frame(2, 1'b1, '0); build_expected();
    run_stream(0, 0, exp_data.size());
    n_cmp++;
    if (obs_data.size() != exp_data.size()) begin
      n_err++; $display("FAIL midrst_count: got %0d want %0d", obs_data.size(), exp_data.size());
    end
    for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
      n_cmp++;
      if (obs_data[i] !== exp_data[i] || obs_last[i] !== exp_last[i]) begin
        n_err++;
        $display("FAIL midrst_beat%0d: got %h/%b want %h/%b", i, obs_data[i], obs_last[i], exp_data[i], exp_last[i]);
      end
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      clear_stim();
      for (int f = 0; f < 3; f++) add_frame($urandom_range(1, 12), 1'b1, '0);
      build_expected();
      run_stream($urandom_range(0, 50), 2, exp_data.size());
      n_cmp++;
      if (obs_data.size() != exp_data.size()) begin
        n_err++; $display("FAIL rand%0d_count: got %0d want %0d", r, obs_data.size(), exp_data.size());
      end
      for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
        n_cmp++;
        if (obs_data[i] !== exp_data[i] || obs_last[i] !== exp_last[i]) begin
          n_err++;
          $display("FAIL rand%0d_beat%0d: got %h/%b want %h/%b", r, i, obs_data[i], obs_last[i], exp_data[i], exp_last[i]);
        end
      end
      n_cmp++;
      if (stab_err != 0 || max_lead > 2 || overflow !== exp_ovf || frame_len !== FLW'(exp_flen)) begin
        n_err++;
        $display("FAIL rand%0d_flags: stab=%0d lead=%0d ovf=%b flen=%0d want 0/<=2/%b/%0d", r, stab_err, max_lead, overflow, frame_len, exp_ovf, exp_flen);
      end
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_single();
    test_back_to_back();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axis_bram_frame_ctrl.md
Name: axis_bram_frame_ctrl

Overview:
Sequencer that owns the single port of the team's BRAM model and uses it as a frame store-and-forward buffer. An AXI-Stream slave frame is written into BRAM from address 0 (FILL), then read back in order on an AXI-Stream master (DRAIN), and the block returns to FILL. It absorbs the BRAM's one-cycle read latency with a 2-entry output buffer, so sustained drain throughput is one beat per cycle.

Parameters:
C_AXIS_BRAM_ADDR_WIDTH, 12, BRAM address width.
C_AXIS_BRAM_DATA_WIDTH, 64, stream and BRAM data width (multiple of 8).
C_AXIS_BRAM_DEPTH, 2**C_AXIS_BRAM_ADDR_WIDTH, maximum words per frame.

Ports:
clk  in  1  single clock for all logic.
reset_n  in  1  reset, synchronous, active-low.
s_axis_tdata  in  DATA_WIDTH  input frame data.
s_axis_tvalid  in  1  input beat valid.
s_axis_tready  out  1  input beat accepted when tvalid&tready.
s_axis_tlast  in  1  last beat of input frame.
m_axis_tdata  out  DATA_WIDTH  output frame data.
m_axis_tvalid  out  1  output beat valid.
m_axis_tready  in  1  downstream ready.
m_axis_tlast  out  1  last beat of output frame.
bram_addr  out  ADDR_WIDTH  BRAM address.
bram_din  out  DATA_WIDTH  BRAM write data.
bram_dout  in  DATA_WIDTH  BRAM read data, valid the cycle after a sampled bram_en.
bram_en  out  1  BRAM read enable.
bram_we  out  DATA_WIDTH/8  BRAM byte write enables (all-or-nothing).
frame_len  out  ADDR_WIDTH+1  length of the frame currently held/draining.
overflow  out  1  sticky flag: a frame was truncated at DEPTH words.

Behaviour:
- Reset (reset_n low at posedge): state=FILL, wr_ptr=0, rd_ptr=0, inflight=0, buffer empty, frame_len=0, overflow=0. While reset_n is low, s_axis_tready, m_axis_tvalid, bram_en and bram_we are forced to 0. Reset mid-frame discards all stored data. BRAM contents are not cleared.
- FILL: s_axis_tready=1. On an accepted beat, the same cycle drives bram_we=all ones, bram_addr=wr_ptr, bram_din=s_axis_tdata, and wr_ptr increments. bram_en=0 throughout FILL.
- FILL exit: if the accepted beat has tlast=1, or wr_ptr==DEPTH-1, then frame_len<=wr_ptr+1, wr_ptr<=0, and the next state is DRAIN.
- FILL overflow: if the DEPTH-1 exit is taken without tlast, overflow<=1. The remaining input beats stay stalled and become the start of the next frame.
- DRAIN: s_axis_tready=0, bram_we=0.
- DRAIN read issue: bram_en=1 with bram_addr=rd_ptr when rd_ptr<frame_len and (buf_count + inflight - pop) < 2, where pop = m_axis_tvalid & m_axis_tready. Each issue increments rd_ptr.
- DRAIN capture: inflight<=issue. When inflight=1, bram_dout is pushed into the buffer at the next posedge.
- DRAIN output: m_axis_tvalid = buffer non-empty, m_axis_tdata = buffer head. m_axis_tlast=1 only on the beat whose index is frame_len-1. tdata and tlast are held stable while tvalid & !tready.
- Latency: the first m_axis_tvalid appears 2 cycles after DRAIN entry. With m_axis_tready held high, output runs one beat per cycle with no bubbles.
- DRAIN exit: on the tlast handshake, rd_ptr<=0 and state<=FILL. s_axis_tready rises in the following cycle. frame_len holds until the next FILL exit.
- Simultaneous push and pop in the buffer are both honoured (count unchanged).
- The buffer never overflows (guaranteed by the credit rule) and pop never occurs when empty.
- Width rules: wr_ptr and rd_ptr are ADDR_WIDTH+1 bits, so a count of DEPTH is representable. bram_addr uses the low ADDR_WIDTH bits.

Decomposition:
- Package axis_bram_pkg holds:
  - the state enum (FILL, DRAIN);
  - a function for the all-ones byte-enable constant, width DATA_WIDTH/8;
  - a pointer-width constant, ADDR_WIDTH+1.
- One sub-module, axis_bram_rdbuf: 2-entry FIFO with push, pop, count and head data. It exports count for the credit rule.

Test Plan:
- Frame of 4 beats (0x11,0x22,0x33,0x44, tlast on 0x44), m_axis_tready=1 -> writes to addresses 0..3; frame_len=4; output 0x11..0x44 on consecutive cycles, first tvalid 2 cycles after DRAIN entry, tlast only on 0x44.
- Same frame with m_axis_tready toggling 1,0,0,1,... -> no beat lost or duplicated; data and tlast stable while stalled; at most 2 bram_en cycles ahead of consumption.
- ADDR_WIDTH=3 (DEPTH=8), 10-beat frame -> first 8 beats drained with tlast on beat 8; overflow=1; beats 9-10 then form the next 2-beat frame.
- Single-beat frame (tlast on first beat) -> frame_len=1; exactly one bram_en; one output beat with tlast=1.
- Back-to-back frames of 3 and 5 beats with s_axis_tvalid always high -> s_axis_tready low throughout each DRAIN; second frame's data is correct and not corrupted by stale buffer entries.
- reset_n pulled low for 1 cycle mid-DRAIN after 2 of 6 beats -> m_axis_tvalid=0, overflow=0, frame_len=0, state FILL; the next 2-beat frame drains correctly.
